// File: rtl/osc_pkg.sv
// Shared types for the oscilloscope capture path: capture FSM states and sample width.
package osc_pkg;

  localparam int unsigned OSC_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST_FILL,
    DONE
  } cap_state_e;

  function automatic logic is_capturing(input cap_state_e s);
    return (s == PRE_FILL) || (s == WAIT_TRIG) || (s == POST_FILL);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port frame buffer: one synchronous write port and one registered read port on one clock.
module capture_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ad_trigger_capture.sv
// Level/slope triggered frame capture with pre-trigger history and frozen readout by logical index.
// Optional forced trigger after a timeout is enabled by defining AUTO_TRIG_EN.
module ad_trigger_capture
  import osc_pkg::*;
#(
  parameter int unsigned DATA_W       = OSC_DATA_W,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned PRE_TRIG     = 256,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              capture_done,
  output logic              trig_forced
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned POST_CNT = DEPTH - PRE_TRIG;

  localparam logic [ADDR_W:0]   PRE_CNT_C  = PRE_TRIG[ADDR_W:0];
  localparam logic [ADDR_W:0]   POST_CNT_C = POST_CNT[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PRE_OFF    = PRE_TRIG[ADDR_W-1:0];

  if (PRE_TRIG < 1 || PRE_TRIG >= DEPTH || AUTO_TIMEOUT < 1) begin : g_bad_cfg
    $error("ad_trigger_capture: PRE_TRIG must be 1..DEPTH-1 and AUTO_TIMEOUT >= 1");
  end

  cap_state_e        state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] trig_ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] prev_q;
  logic              busy_q;
  logic              done_q;
  logic              forced_q;

  logic              cap_wr;
  logic [ADDR_W:0]   cnt_inc;
  logic              rise_hit;
  logic              fall_hit;
  logic              level_hit;
  logic              timeout_hit;
  logic [ADDR_W-1:0] frame_start;
  logic [ADDR_W-1:0] rd_phys_d;

  assign cap_wr  = sample_valid && is_capturing(state_q);
  assign cnt_inc = cnt_q + CNT_ONE;

  assign rise_hit  = (prev_q < trig_level) && (sample_in >= trig_level);
  assign fall_hit  = (prev_q > trig_level) && (sample_in <= trig_level);
  assign level_hit = trig_slope ? fall_hit : rise_hit;

`ifdef AUTO_TRIG_EN
  localparam int unsigned     TMO_W    = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q;

  // Counts strobes spent in WAIT_TRIG; cleared whenever the FSM is elsewhere.
  always_ff @(posedge sys_clk) begin
    if (rst || state_q != WAIT_TRIG) begin
      tmo_q <= '0;
    end else if (sample_valid) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign timeout_hit = (tmo_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      forced_q   <= 1'b0;
    end else begin
      if (cap_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        prev_q   <= sample_in;
      end

      unique case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_q  <= PRE_FILL;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            forced_q <= 1'b0;
          end
        end

        PRE_FILL: begin
          if (sample_valid) begin
            if (cnt_inc == PRE_CNT_C) begin
              state_q <= WAIT_TRIG;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        // The trigger sample itself is the first post-trigger sample, so the
        // post counter starts at one (or the frame completes immediately).
        WAIT_TRIG: begin
          if (sample_valid && (level_hit || timeout_hit)) begin
            trig_ptr_q <= wr_ptr_q;
            forced_q   <= !level_hit;
            if (POST_CNT == 1) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= POST_FILL;
              cnt_q   <= CNT_ONE;
            end
          end
        end

        POST_FILL: begin
          if (sample_valid) begin
            if (cnt_inc == POST_CNT_C) begin
              state_q <= DONE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Logical index 0 is the oldest pre-trigger sample; address arithmetic wraps at DEPTH.
  assign frame_start = trig_ptr_q - PRE_OFF;
  assign rd_phys_d   = frame_start + rd_addr;

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .we_i    (cap_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (sample_in),
    .raddr_i (rd_phys_d),
    .rdata_o (rd_data)
  );

  assign busy         = busy_q;
  assign capture_done = done_q;
  assign trig_forced  = forced_q;

endmodule

// File: tb/tb_ad_trigger_capture.sv
// Directed/randomized bench for ad_trigger_capture with a sample-history reference model.
module tb_ad_trigger_capture;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned PRE   = 256;
  localparam int unsigned POST  = DEPTH - PRE;
  localparam int unsigned TMO   = 4096;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       arm;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       capture_done;
  logic       trig_forced;

  always #5 sys_clk = ~sys_clk;

  ad_trigger_capture #(
    .DATA_W       (8),
    .ADDR_W       (10),
    .PRE_TRIG     (PRE),
    .AUTO_TIMEOUT (TMO)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .capture_done (capture_done),
    .trig_forced  (trig_forced)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] hist[$];
  logic [7:0] frame    [DEPTH];
  logic [7:0] t1_frame [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first strobe after the pre-fill whose (previous, current) pair crosses the level.
  function automatic int model_k(input logic [7:0] lvl, input logic slope, output logic forced);
    logic hit;
    forced = 1'b0;
    for (int i = PRE; i < hist.size(); i++) begin
      hit = slope ? (hist[i-1] > lvl && hist[i] <= lvl) : (hist[i-1] < lvl && hist[i] >= lvl);
      if (hit) return i;
`ifdef AUTO_TRIG_EN
      if (i - PRE + 1 == TMO) begin
        forced = 1'b1;
        return i;
      end
`endif
    end
    return -1;
  endfunction

  function automatic logic [7:0] gen(input int mode, input int unsigned i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'hFF - 8'(i);
      2:       return 8'h10;
      3:       return 8'($urandom);
      default: return (i < PRE) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
    endcase
  endfunction

  task automatic feed(input logic [7:0] s, input int unsigned gap);
    @(negedge sys_clk);
    sample_in    = s;
    sample_valid = 1'b1;
    @(negedge sys_clk);
    sample_valid = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic read_frame();
    @(negedge sys_clk);
    rd_addr = '0;
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge sys_clk);
      frame[j] = rd_data;
      rd_addr  = 10'(j + 1);
    end
  endtask

  task automatic frame_cmp(input string tag, input int k);
    int unsigned bad = 0;
    int first = -1;
    logic [7:0] e;
    logic [7:0] o;
    for (int j = 0; j < DEPTH; j++) begin
      int idx = k - PRE + j;
      logic [7:0] ex = (idx >= 0 && idx < hist.size()) ? hist[idx] : 8'hxx;
      if (frame[j] !== ex || idx >= hist.size()) begin
        bad++;
        if (first < 0) begin
          first = j;
          e = ex;
          o = frame[j];
        end
      end
    end
    n_cmp++;
    assert (bad == 0) else begin
      n_bad++;
      $error("FAIL %s_frame: %0d bad entries, first idx %0d observed=%0h expected=%0h",
             tag, bad, first, o, e);
    end
  endtask

  task automatic capture(input string tag, input int mode, input logic [7:0] lvl,
                         input logic slope, input int unsigned limit, input int unsigned gapmax,
                         input int arm_at, input int rst_at, input logic coincide,
                         output logic aborted);
    logic [7:0] s;
    logic       fexp;
    int         k;
    aborted = 1'b0;
    hist.delete();
    trig_level = lvl;
    trig_slope = slope;
    @(negedge sys_clk);
    arm = 1'b1;
    if (coincide) begin
      sample_in    = 8'hEE;
      sample_valid = 1'b1;
    end
    @(negedge sys_clk);
    arm          = 1'b0;
    sample_valid = 1'b0;
    chk({tag, "_busy_armed"}, 32'(busy), 32'd1);
    chk({tag, "_done_armed"}, 32'(capture_done), 32'd0);

    while (!capture_done && hist.size() < limit) begin
      s = gen(mode, hist.size());
      hist.push_back(s);
      feed(s, $urandom_range(0, gapmax));
      if (hist.size() == arm_at) begin
        @(negedge sys_clk) arm = 1'b1;
        @(negedge sys_clk) arm = 1'b0;
      end
      if (hist.size() == rst_at) begin
        @(negedge sys_clk) rst = 1'b1;
        @(negedge sys_clk) rst = 1'b0;
        chk({tag, "_busy_after_rst"}, 32'(busy), 32'd0);
        chk({tag, "_done_after_rst"}, 32'(capture_done), 32'd0);
        aborted = 1'b1;
        return;
      end
    end

    k = model_k(lvl, slope, fexp);
    if (k >= 0) begin
      chk({tag, "_len"}, 32'(hist.size()), 32'(k + POST));
      chk({tag, "_done"}, 32'(capture_done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_forced"}, 32'(trig_forced), 32'(fexp));
      read_frame();
      frame_cmp(tag, k);
    end else begin
      chk({tag, "_done_none"}, 32'(capture_done), 32'd0);
      chk({tag, "_busy_none"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    logic ab;
    int unsigned same;
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    arm          = 1'b0;
    trig_level   = '0;
    trig_slope   = 1'b0;
    rd_addr      = '0;

    repeat (2) @(negedge sys_clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(capture_done), 32'd0);
    chk("rst_forced", 32'(trig_forced), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    @(negedge sys_clk);

    // T1 rising ramp
    capture("t1", 0, 8'h80, 1'b0, 3000, 2, -1, -1, 1'b0, ab);
    for (int j = 0; j < DEPTH; j++) t1_frame[j] = frame[j];
    chk("t1_rd256", 32'(frame[256]), 32'h80);
    chk("t1_rd255", 32'(frame[255]), 32'h7F);
    chk("t1_rd0", 32'(frame[0]), 32'h80);

    // T2 falling ramp
    capture("t2", 1, 8'h40, 1'b1, 3000, 2, -1, -1, 1'b0, ab);
    chk("t2_rd256", 32'(frame[256]), 32'h40);
    chk("t2_rd257", 32'(frame[257]), 32'h3F);

    // T4 arm pulse while waiting for trigger
    capture("t4", 0, 8'h80, 1'b0, 3000, 2, 300, -1, 1'b0, ab);
    same = 0;
    for (int j = 0; j < DEPTH; j++) if (frame[j] === t1_frame[j]) same++;
    chk("t4_same_as_t1", same, DEPTH);

    // T5 reset during post-fill, then a fresh capture
    capture("t5a", 0, 8'h80, 1'b0, 3000, 2, -1, 600, 1'b0, ab);
    chk("t5_aborted", 32'(ab), 32'd1);
    capture("t5b", 0, 8'h80, 1'b0, 3000, 2, -1, -1, 1'b0, ab);
    same = 0;
    for (int j = 0; j < DEPTH; j++) if (frame[j] === t1_frame[j]) same++;
    chk("t5_same_as_t1", same, DEPTH);

    // T6 arm coincident with a strobe: that sample is dropped
    capture("t6", 4, 8'h80, 1'b0, 3000, 2, -1, -1, 1'b1, ab);
    chk("t6_rd0", 32'(frame[0]), 32'(hist[0]));

    // Random data, random level and slope
    for (int r = 0; r < 2; r++) begin
      capture($sformatf("rnd%0d", r), 3, 8'($urandom_range(32, 224)), 1'($urandom_range(0, 1)),
              6000, 2, -1, -1, 1'b0, ab);
    end

    // T3 constant input never crosses the level
    capture("t3", 2, 8'h80, 1'b0, 10000, 0, -1, -1, 1'b0, ab);
`ifdef AUTO_TRIG_EN
    chk("t3_forced", 32'(trig_forced), 32'd1);
    chk("t3_rd256", 32'(frame[256]), 32'h10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
